// File: rtl/aes_pkg.sv
// Shared AES types and constants.
// Includes the helpers used by the inverse key schedule.
package aes_pkg;

  typedef logic [7:0]   aes_byte;
  typedef logic [31:0]  aes_32;
  typedef logic [127:0] key_128;

  localparam logic [3:0] AES_NUM_ROUNDS = 4'd10;
  localparam aes_byte    RCON_LAST      = 8'h36;

  typedef enum logic [1:0] {
    KG_IDLE = 2'd0,
    KG_WALK = 2'd1,
    KG_DONE = 2'd2
  } inv_kg_state_t;

  // Undo xtime in GF(2^8); the 0x1b fold restores the dropped top bit.
  function automatic aes_byte inv_xtime(aes_byte b);
    if (!b[0]) return b >> 1;
    return ((b ^ 8'h1b) >> 1) | 8'h80;
  endfunction

endpackage

// File: rtl/aes_inv_key_step.sv
// One backward step of the AES-128 key schedule.
// Pure combinational; S-box lookup happens outside.
module aes_inv_key_step
  import aes_pkg::*;
(
  input  key_128  key_i,
  input  aes_32   sub_i,
  input  aes_byte rcon_i,
  output key_128  prev_o,
  output aes_32   sub_o
);

  aes_32 w_w0, w_w1, w_w2, w_w3;
  aes_32 w_p0, w_p1, w_p2, w_p3;

  assign {w_w0, w_w1, w_w2, w_w3} = key_i;

  assign w_p3 = w_w3 ^ w_w2;
  assign w_p2 = w_w2 ^ w_w1;
  assign w_p1 = w_w1 ^ w_w0;
  assign w_p0 = w_w0 ^ sub_i ^ {rcon_i, 24'h0};

  assign sub_o  = {w_p3[23:0], w_p3[31:24]};
  assign prev_o = {w_p0, w_p1, w_p2, w_p3};

endmodule

// File: rtl/aes_inv_key_gen.sv
// Inverse AES-128 key schedule: walks round keys 10 down to 0.
// Shares an external S-box through sub_o/sub_i.
module aes_inv_key_gen
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic       en,
  input  logic       load,
  input  logic       next_rnd,
  input  key_128     key_i,
  input  aes_32      sub_i,
  output aes_32      sub_o,
  output key_128     key_o,
  output logic [3:0] rnd_o,
  output logic       valid_o,
  output logic       done_o
);

  inv_kg_state_t r_state;
  key_128        r_key;
  logic [3:0]    r_rnd;
  aes_byte       r_rcon;
  key_128        w_prev;
  logic          w_step;

  aes_inv_key_step u_step (
    .key_i  (r_key),
    .sub_i  (sub_i),
    .rcon_i (r_rcon),
    .prev_o (w_prev),
    .sub_o  (sub_o)
  );

  assign w_step = next_rnd && (r_state == KG_WALK);

  always_ff @(posedge clk) begin
    if (nrst) begin
      r_state <= KG_IDLE;
      r_key   <= '0;
      r_rnd   <= '0;
      r_rcon  <= RCON_LAST;
    end else if (en) begin
      if (load) begin
        r_state <= KG_WALK;
        r_key   <= key_i;
        r_rnd   <= AES_NUM_ROUNDS;
        r_rcon  <= RCON_LAST;
      end else if (w_step) begin
        r_key   <= w_prev;
        r_rnd   <= r_rnd - 4'd1;
        r_rcon  <= inv_xtime(r_rcon);
        r_state <= (r_rnd == 4'd1) ? KG_DONE : KG_WALK;
      end
    end
  end

  assign key_o   = r_key;
  assign rnd_o   = r_rnd;
  assign valid_o = (r_state != KG_IDLE);
  assign done_o  = (r_state == KG_DONE);

endmodule

// File: tb/tb_aes_inv_key_gen.sv
// Directed bench for aes_inv_key_gen.
// FIPS-197 key 2b7e1516... walked backwards from round 10.
module tb_aes_inv_key_gen;

  logic         clk = 1'b0;
  logic         nrst, en, load, next_rnd;
  logic [127:0] key_i, key_o;
  logic [31:0]  sub_i, sub_o;
  logic [3:0]   rnd_o;
  logic         valid_o, done_o;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] sbox [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  logic [127:0] rk [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  assign sub_i = {sbox[sub_o[31:24]], sbox[sub_o[23:16]],
                  sbox[sub_o[15:8]],  sbox[sub_o[7:0]]};

  aes_inv_key_gen dut (
    .clk      (clk),
    .nrst     (nrst),
    .en       (en),
    .load     (load),
    .next_rnd (next_rnd),
    .key_i    (key_i),
    .sub_i    (sub_i),
    .sub_o    (sub_o),
    .key_o    (key_o),
    .rnd_o    (rnd_o),
    .valid_o  (valid_o),
    .done_o   (done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_key"},   key_o,   '0);
    check({tag, "_rnd"},   rnd_o,   '0);
    check({tag, "_valid"}, valid_o, '0);
    check({tag, "_done"},  done_o,  '0);
  endtask

  initial begin
    nrst = 1'b1; en = 1'b1; load = 1'b0;
    next_rnd = 1'b0; key_i = '0;
    @(negedge clk);
    tick(2);
    check_idle("rst");
    check("rst_sub", sub_o, '0);

    nrst = 1'b0; next_rnd = 1'b1;
    tick(2);
    check_idle("idle_nr");

    next_rnd = 1'b0; load = 1'b1; key_i = rk[10];
    tick(1);
    load = 1'b0;
    check("ld_key",   key_o,   rk[10]);
    check("ld_rnd",   rnd_o,   4'd10);
    check("ld_valid", valid_o, 1'b1);
    check("ld_done",  done_o,  1'b0);
    check("ld_sub",   sub_o,   32'h5c006e57);

    next_rnd = 1'b1;
    tick(1);
    check("r9_key", key_o, rk[9]);
    check("r9_rnd", rnd_o, 4'd9);
    tick(8);
    check("r1_key", key_o, rk[1]);
    check("r1_rnd", rnd_o, 4'd1);
    check("r1_done", done_o, 1'b0);
    tick(1);
    check("r0_key",  key_o,  rk[0]);
    check("r0_rnd",  rnd_o,  4'd0);
    check("r0_done", done_o, 1'b1);
    tick(1);
    check("r0x_key",  key_o,  rk[0]);
    check("r0x_rnd",  rnd_o,  4'd0);
    check("r0x_done", done_o, 1'b1);

    next_rnd = 1'b0; load = 1'b1;
    tick(1);
    load = 1'b0; next_rnd = 1'b1;
    check("rl_done", done_o, 1'b0);
    tick(4);
    check("r6_key", key_o, rk[6]);
    en = 1'b0;
    tick(3);
    check("hold_key",   key_o,   rk[6]);
    check("hold_rnd",   rnd_o,   4'd6);
    check("hold_valid", valid_o, 1'b1);
    check("hold_sub",   sub_o,   32'hf915bc11);
    en = 1'b1;
    tick(1);
    check("r5_key", key_o, rk[5]);
    check("r5_rnd", rnd_o, 4'd5);
    tick(1);
    check("r4_key", key_o, rk[4]);

    load = 1'b1;
    tick(1);
    load = 1'b0;
    check("lnr_key", key_o, rk[10]);
    check("lnr_rnd", rnd_o, 4'd10);
    tick(3);
    check("r7_key", key_o, rk[7]);
    check("r7_rnd", rnd_o, 4'd7);

    nrst = 1'b1;
    tick(1);
    check_idle("mrst");
    nrst = 1'b0; next_rnd = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
